// File: rtl/wb_mbox_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mbox_fifo_pkg
//  Purpose  : Shared constants for the inter-core Wishbone mailbox FIFO.
//             This package holds the slave word address used by the bus
//             controller decode, the default FIFO depth, and the status bit
//             positions reserved for a future status register.
//  Revision : 1.0  initial release
// ============================================================================
package wb_mbox_fifo_pkg;

    // Word address decoded upstream by the two-core bus controller (slave 1).
    localparam logic [31:0] MBOX_ADDR      = 32'h0000_0801;

    // Default number of FIFO entries. It must be a power of 2 and at least 2.
    localparam int          MBOX_DEPTH_DEF = 8;

    // Bit positions for a future memory-mapped status register.
    localparam int          STS_EMPTY_BIT  = 0;
    localparam int          STS_FULL_BIT   = 1;
    localparam int          STS_OVF_BIT    = 2;
    localparam int          STS_UDF_BIT    = 3;
    localparam int          STS_IRQ_BIT    = 4;

endpackage : wb_mbox_fifo_pkg
`default_nettype wire

// File: rtl/mbox_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : mbox_fifo_mem
//  Purpose  : DEPTH x DWIDTH register array for the mailbox FIFO.
//             Writes are synchronous. Reads are asynchronous, so the head
//             word is available in the same cycle the read is accepted.
//             The storage has no reset.
//  Ports    : i_wb_clk  clock
//             i_we      write strobe
//             i_waddr   write address (write pointer)
//             i_wdata   write word (byte-masked by the caller)
//             i_raddr   read address (read pointer)
//             o_rdata   word at i_raddr
//  Revision : 1.0  initial release
// ============================================================================
module mbox_fifo_mem
    import wb_mbox_fifo_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = MBOX_DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_wb_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_wb_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : mbox_fifo_mem
`default_nettype wire

// File: rtl/wb_mbox_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mbox_fifo
//  Purpose  : Wishbone inter-core mailbox. A write pushes a word into the
//             FIFO and a read pops the head word. Each access is acked one
//             cycle after it is accepted. No new request is taken while ack
//             is high, so the arbiter can switch masters on ack safely.
//  Config   : WB_MBOX_IRQ_EN  defined   -> o_irq = (count >= IRQ_THRESH)
//                                           | o_overflow (registered)
//                             undefined -> o_irq tied to 0
//  Ports    : i_wb_clk, i_arst_n (async, active-low)
//             i_wb_adr/sel/we/dat/cyc/stb, o_wb_dat/ack  Wishbone slave
//             i_flag_clr      clears the sticky overflow/underflow flags
//             o_count/empty/full  registered occupancy status
//             o_overflow/underflow  sticky error flags
//             o_irq           mailbox interrupt
//  Revision : 1.0  initial release
// ============================================================================
module wb_mbox_fifo
    import wb_mbox_fifo_pkg::*;
#(
    parameter int WB_DWIDTH  = 32,
    parameter int WB_SWIDTH  = 4,
    parameter int DEPTH      = MBOX_DEPTH_DEF,
    parameter int IRQ_THRESH = 1
) (
    input  logic                     i_wb_clk,
    input  logic                     i_arst_n,
    input  logic [31:0]              i_wb_adr,
    input  logic [WB_SWIDTH-1:0]     i_wb_sel,
    input  logic                     i_wb_we,
    input  logic [WB_DWIDTH-1:0]     i_wb_dat,
    output logic [WB_DWIDTH-1:0]     o_wb_dat,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    output logic                     o_wb_ack,
    input  logic                     i_flag_clr,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic                     o_underflow,
    output logic                     o_irq
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(DEPTH);

    logic [WB_DWIDTH-1:0] r_dat;
    logic                 r_ack;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_ovf;
    logic                 r_udf;
    logic                 r_irq;

    logic                 w_req;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ovf_nxt;
    logic                 w_udf_nxt;
    logic [c_PTR_W:0]     w_count_nxt;
    logic [WB_DWIDTH-1:0] w_wdata;
    logic [WB_DWIDTH-1:0] w_head;
    logic                 w_unused;

    // Gating on our own ack blocks a stale request in the ack cycle, so the
    // best-case rate is one access every two cycles.
    assign w_req  = i_wb_cyc & i_wb_stb & ~r_ack;
    assign w_wr   = w_req &  i_wb_we;
    assign w_rd   = w_req & ~i_wb_we;
    assign w_push = w_wr & ~r_full;
    assign w_pop  = w_rd & ~r_empty;

    // Setting a flag takes priority over a coincident clear.
    assign w_ovf_nxt = (w_wr & r_full)  | (r_ovf & ~i_flag_clr);
    assign w_udf_nxt = (w_rd & r_empty) | (r_udf & ~i_flag_clr);

    // Bytes that are not selected are stored as zero.
    for (genvar b = 0; b < WB_SWIDTH; b++) begin : g_byte
        assign w_wdata[b*8 +: 8] = i_wb_sel[b] ? i_wb_dat[b*8 +: 8] : 8'h00;
    end

    // Push and pop never coincide because the port is single-access.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    mbox_fifo_mem #(
        .DWIDTH (WB_DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (c_PTR_W)
    ) u_mem (
        .i_wb_clk (i_wb_clk),
        .i_we     (w_push),
        .i_waddr  (r_wr_ptr),
        .i_wdata  (w_wdata),
        .i_raddr  (r_rd_ptr),
        .o_rdata  (w_head)
    );

    always_ff @(posedge i_wb_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_CNT_FULL);
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            // Read data only changes on a read; an empty read returns zero.
            if (w_rd) begin
                r_dat <= r_empty ? '0 : w_head;
            end
        end
    end

`ifdef WB_MBOX_IRQ_EN
    localparam logic [c_PTR_W:0] c_IRQ_THRESH = (c_PTR_W + 1)'(IRQ_THRESH);

    // Built from next-state values so the interrupt moves with o_count.
    always_ff @(posedge i_wb_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_count_nxt >= c_IRQ_THRESH) | w_ovf_nxt;
        end
    end
    assign w_unused = ^i_wb_adr;
`else
    assign r_irq    = 1'b0;
    assign w_unused = ^{i_wb_adr, IRQ_THRESH};
`endif

    assign o_wb_ack    = r_ack;
    assign o_wb_dat    = r_dat;
    assign o_count     = r_count;
    assign o_empty     = r_empty;
    assign o_full      = r_full;
    assign o_overflow  = r_ovf;
    assign o_underflow = r_udf;
    assign o_irq       = r_irq;

endmodule : wb_mbox_fifo
`default_nettype wire

// File: tb/tb_wb_mbox_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_mbox_fifo
//  Purpose  : Self-checking bench for wb_mbox_fifo (DEPTH=8, IRQ_THRESH=2).
//             A table of single Wishbone transfers is checked first, followed
//             by hand-written sequences for flag clear, back-to-back strobe,
//             pointer wrap and asynchronous reset during a pending ack.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_mbox_fifo;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [31:0] adr = 32'h801;
    logic [3:0]  sel = 4'h0;
    logic        we = 1'b0;
    logic [31:0] wdat = '0;
    logic [31:0] rdat;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        ack;
    logic        flag_clr = 1'b0;
    logic [3:0]  count;
    logic        empty, full, ovf, udf, irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_mbox_fifo #(
        .WB_DWIDTH  (32),
        .WB_SWIDTH  (4),
        .DEPTH      (8),
        .IRQ_THRESH (2)
    ) dut (
        .i_wb_clk    (clk),
        .i_arst_n    (arst_n),
        .i_wb_adr    (adr),
        .i_wb_sel    (sel),
        .i_wb_we     (we),
        .i_wb_dat    (wdat),
        .o_wb_dat    (rdat),
        .i_wb_cyc    (cyc),
        .i_wb_stb    (stb),
        .o_wb_ack    (ack),
        .i_flag_clr  (flag_clr),
        .o_count     (count),
        .o_empty     (empty),
        .o_full      (full),
        .o_overflow  (ovf),
        .o_underflow (udf),
        .o_irq       (irq)
    );

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp_dat;
        int          exp_cnt;
        logic        exp_ovf;
        logic        exp_udf;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_irq(input int cnt, input logic f_ovf);
`ifdef WB_MBOX_IRQ_EN
        return (cnt >= 2) | f_ovf;
`else
        return 1'b0 & f_ovf & (cnt != 0);
`endif
    endfunction

    function automatic vec_t mk(input logic v_we, input logic [3:0] v_sel,
                                input logic [31:0] v_dat, input logic [31:0] v_exp,
                                input int v_cnt, input logic v_ovf, input logic v_udf);
        vec_t v;
        v.we = v_we; v.sel = v_sel; v.dat = v_dat; v.exp_dat = v_exp;
        v.exp_cnt = v_cnt; v.exp_ovf = v_ovf; v.exp_udf = v_udf;
        return v;
    endfunction

    // One complete transfer: accepted on the first edge, ack must be high
    // right after it and low again one cycle later.
    task automatic xfer(input logic t_we, input logic [3:0] t_sel, input logic [31:0] t_dat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = t_we; sel = t_sel; wdat = t_dat;
        @(posedge clk); #1;
        chk("ack_rise", {31'b0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("ack_fall", {31'b0, ack}, 32'd0);
    endtask

    task automatic chk_status(input string tag, input int e_cnt, input logic e_ovf, input logic e_udf);
        chk({tag, "_count"}, {28'b0, count}, e_cnt);
        chk({tag, "_empty"}, {31'b0, empty}, {31'b0, e_cnt == 0});
        chk({tag, "_full"},  {31'b0, full},  {31'b0, e_cnt == 8});
        chk({tag, "_ovf"},   {31'b0, ovf},   {31'b0, e_ovf});
        chk({tag, "_udf"},   {31'b0, udf},   {31'b0, e_udf});
        chk({tag, "_irq"},   {31'b0, irq},   {31'b0, exp_irq(e_cnt, e_ovf)});
    endtask

    logic [31:0] q[$];
    int          acks;

    initial begin
        // ---- vector table -------------------------------------------------
        vt.push_back(mk(1, 4'hF, 32'h1234_5678, 32'h0,          1, 0, 0));
        vt.push_back(mk(0, 4'hF, 32'h0,         32'h1234_5678, 0, 0, 0));
        vt.push_back(mk(1, 4'h5, 32'hAABB_CCDD, 32'h1234_5678, 1, 0, 0));
        vt.push_back(mk(0, 4'hF, 32'h0,         32'h00BB_00DD, 0, 0, 0));
        for (int i = 1; i <= 8; i++)
            vt.push_back(mk(1, 4'hF, i, 32'h00BB_00DD, i, 0, 0));
        vt.push_back(mk(1, 4'hF, 32'd9, 32'h00BB_00DD, 8, 1, 0));
        for (int i = 1; i <= 8; i++)
            vt.push_back(mk(0, 4'hF, 32'h0, i, 8 - i, 1, 0));
        vt.push_back(mk(0, 4'hF, 32'h0, 32'h0, 0, 1, 1));

        // ---- reset state --------------------------------------------------
        #12;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", rdat, 32'h0);
        chk_status("rst", 0, 0, 0);
        @(negedge clk);
        arst_n = 1'b1;

        // ---- table-driven transfers --------------------------------------
        for (int i = 0; i < vt.size(); i++) begin
            xfer(vt[i].we, vt[i].sel, vt[i].dat);
            chk($sformatf("v%0d_dat", i), rdat, vt[i].exp_dat);
            chk_status($sformatf("v%0d", i), vt[i].exp_cnt, vt[i].exp_ovf, vt[i].exp_udf);
        end

        // ---- flag clear ---------------------------------------------------
        @(negedge clk);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        chk_status("clr", 0, 0, 0);

        // ---- strobe held high for 4 writes --------------------------------
        acks = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; wdat = 32'h100;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_ack%0d", c), {31'b0, ack}, {31'b0, (c % 2) == 0});
            if (ack) begin
                q.push_back(wdat);
                acks++;
                wdat = wdat + 32'd1;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk("b2b_acks", acks, 32'd4);
        @(negedge clk);
        chk_status("b2b", 4, 0, 0);

        // ---- pointer wrap: write/read pairs ------------------------------
        for (int p = 0; p < 6; p++) begin
            xfer(1, 4'hF, 32'h200 + p);
            q.push_back(32'h200 + p);
            xfer(0, 4'hF, 32'h0);
            chk($sformatf("wrap%0d_dat", p), rdat, q.pop_front());
        end
        chk_status("wrap", 4, 0, 0);

        // ---- async reset with an ack pending and count=3 -----------------
        xfer(0, 4'hF, 32'h0);
        chk("pre_rst_dat", rdat, q.pop_front());
        chk_status("pre_rst", 3, 0, 0);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; wdat = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("pend_ack", {31'b0, ack}, 32'd1);
        arst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0;
        #1;
        chk("arst_ack", {31'b0, ack}, 32'd0);
        chk("arst_dat", rdat, 32'h0);
        chk_status("arst", 0, 0, 0);
        @(negedge clk);
        arst_n = 1'b1;

        // ---- post-reset sanity --------------------------------------------
        xfer(1, 4'hF, 32'hCAFE_F00D);
        chk_status("post_w", 1, 0, 0);
        xfer(0, 4'hF, 32'h0);
        chk("post_dat", rdat, 32'hCAFE_F00D);
        chk_status("post_r", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_wb_mbox_fifo
`default_nettype wire
